// File: rtl/fir_mac_serial.sv
// rtl/fir_mac_serial.sv - serial FIR filter sharing one multiplier and one accumulator
// One sample in, NTAPS MAC cycles, one round/saturate cycle, then a held result.
module fir_mac_serial #(
  parameter int NTAPS  = 63,
  parameter int DW     = 16,
  parameter int CW     = 16,
  parameter int AW     = 40,
  parameter int OW     = 32,
  parameter int OSHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DW-1:0]     in_data,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic signed [CW-1:0]     coef_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OW-1:0]     out_data,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int IW = $clog2(NTAPS);
  localparam int PW = DW + CW;
  localparam int SW = AW + 1;
  localparam logic [IW-1:0]        LAST = IW'(NTAPS - 1);
  localparam logic signed [SW-1:0] RND  = SW'((2 ** OSHIFT) / 2);
  localparam logic signed [SW-1:0] OMAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FINAL, S_OUT} state_t;
  state_t state, state_nxt;

  logic signed [DW-1:0] dline [NTAPS];
  logic signed [CW-1:0] coef  [NTAPS];
  logic [IW-1:0]        wr_ptr;
  logic [IW-1:0]        rd_ptr;
  logic [IW-1:0]        tap;
  logic signed [AW-1:0] acc;
  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] rounded;
  logic signed [SW-1:0] shifted;
  logic                 accept;
  logic                 coef_hit;
  logic                 sat_hi;
  logic                 sat_lo;

  assign accept   = in_valid && (state == S_IDLE);
  assign coef_hit = coef_we && (state == S_IDLE) && (int'(coef_addr) < NTAPS);

  // rd_ptr walks backwards from the newest sample, so tap k meets x[n-k]
  assign prod    = PW'(dline[rd_ptr]) * PW'(coef[tap]);
  assign rounded = SW'(acc) + RND;
  assign shifted = rounded >>> OSHIFT;
  assign sat_hi  = shifted > OMAX;
  assign sat_lo  = shifted < OMIN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)    state_nxt = S_MAC;
      S_MAC:   if (tap == LAST) state_nxt = S_FINAL;
      S_FINAL:                  state_nxt = S_OUT;
      S_OUT:   if (out_ready)   state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_OUT:   out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        dline[i] <= '0;
        coef[i]  <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tap      <= '0;
      acc      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (coef_hit) begin
        coef[coef_addr] <= coef_wdata;
      end
      if (accept) begin
        dline[wr_ptr] <= in_data;
        wr_ptr        <= (wr_ptr == LAST) ? '0 : wr_ptr + IW'(1);
        rd_ptr        <= wr_ptr;
        tap           <= '0;
        acc           <= '0;
      end
      if (state == S_MAC) begin
        acc    <= acc + {{(AW-PW){prod[PW-1]}}, prod};
        tap    <= tap + IW'(1);
        rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - IW'(1);
      end
      if (state == S_FINAL) begin
        out_sat <= sat_hi || sat_lo;
        if (sat_hi) begin
          out_data <= OMAX[OW-1:0];
        end else if (sat_lo) begin
          out_data <= OMIN[OW-1:0];
        end else begin
          out_data <= shifted[OW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_serial.sv
// tb/tb_fir_mac_serial.sv - directed checks of fir_mac_serial
// Two 4-tap instances share stimulus: u_dut unshifted, u_rnd with OSHIFT=2.
module tb_fir_mac_serial;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               coef_we;
  logic [1:0]         coef_addr;
  logic signed [15:0] coef_wdata;
  logic               out_ready;

  logic               in_ready, out_valid, out_sat, busy;
  logic signed [15:0] out_data;
  logic               r_in_ready, r_out_valid, r_out_sat, r_busy;
  logic signed [15:0] r_out_data;

  int checks = 0;
  int errors = 0;

  fir_mac_serial #(.NTAPS(4), .DW(16), .CW(16), .AW(40), .OW(16), .OSHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .busy(busy)
  );

  fir_mac_serial #(.NTAPS(4), .DW(16), .CW(16), .AW(40), .OW(16), .OSHIFT(2)) u_rnd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .out_sat(r_out_sat), .busy(r_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_coef(input int a, input longint v);
    coef_we    = 1'b1;
    coef_addr  = 2'(a);
    coef_wdata = 16'(v);
    @(posedge clk); #1;
    coef_we    = 1'b0;
  endtask

  task automatic wait_out(input bit poke, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 1) begin
        coef_we    = 1'b1;
        coef_addr  = 2'd0;
        coef_wdata = 16'sd100;
      end else begin
        coef_we = 1'b0;
      end
    end while (!out_valid && n < 40);
  endtask

  // offers one sample (optionally with a same-edge coefficient write), returns the held result
  task automatic run_sample(input longint x, input bit cw, input int ca, input longint cv,
                            input bit poke, output longint y, output longint yr, output bit s);
    int w;
    int n;
    in_data  = 16'(x);
    in_valid = 1'b1;
    if (cw) begin
      coef_we    = 1'b1;
      coef_addr  = 2'(ca);
      coef_wdata = 16'(cv);
    end
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_wait", w, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    wait_out(poke, n);
    chk("latency", n, 5);
    chk("rnd_valid", r_out_valid, 1);
    y  = out_data;
    yr = r_out_data;
    s  = out_sat;
    @(posedge clk); #1;
    chk("out_drop", out_valid, 0);
  endtask

  initial begin
    longint y, yr, hold_v;
    bit     s;
    int     n, seen;
    int     exp_imp[4] = '{2, 3, 4, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
    coef_addr = '0; coef_wdata = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    rst_n = 1'b1;

    // impulse response; c[0] written on the same edge as the impulse
    write_coef(1, 2);
    write_coef(2, 3);
    write_coef(3, 4);
    run_sample(1, 1, 0, 1, 0, y, yr, s);
    chk("imp_0", y, 1);
    chk("imp_0_sat", s, 0);
    for (int k = 0; k < 4; k++) begin
      run_sample(0, 0, 0, 0, 0, y, yr, s);
      chk($sformatf("imp_%0d", k + 1), y, exp_imp[k]);
      chk("imp_sat", s, 0);
    end

    // backpressure: result held, a waiting sample accepted only after the handshake
    out_ready = 1'b0;
    in_data = 16'sd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(0, n);
    chk("hold_latency", n, 5);
    chk("hold_first", out_data, 5);
    hold_v = out_data;
    in_data = 16'sd7; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_v);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid_low", out_valid, 0);
    chk("hs_idle", busy, 0);
    @(posedge clk); #1;
    chk("late_accept", busy, 1);
    in_valid = 1'b0;
    wait_out(0, n);
    chk("late_latency", n, 5);
    chk("late_result", out_data, 17);
    @(posedge clk); #1;

    // coefficient write during MAC must be ignored
    run_sample(0, 0, 0, 0, 1, y, yr, s);
    chk("poke_cur", y, 29);
    run_sample(1, 0, 0, 0, 0, y, yr, s);
    chk("poke_next", y, 42);

    // saturation at both rails
    for (int k = 0; k < 4; k++) write_coef(k, 32767);
    for (int k = 0; k < 4; k++) begin
      run_sample(32767, 0, 0, 0, 0, y, yr, s);
      chk("sat_hi_flag", s, 1);
    end
    chk("sat_hi_data", y, 32767);
    for (int k = 0; k < 4; k++) begin
      run_sample(-32768, 0, 0, 0, 0, y, yr, s);
      chk("sat_lo_flag", s, 1);
    end
    chk("sat_lo_data", y, -32768);

    // reset in the middle of MAC discards the result and clears coefficients
    in_data = 16'sd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_sat", out_sat, 0);
    chk("mid_rst_rnd_busy", r_busy, 0);
    chk("mid_rst_rnd_ready", r_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | int'(out_valid);
    end
    chk("no_result_after_rst", seen, 0);
    run_sample(1, 0, 0, 0, 0, y, yr, s);
    chk("zero_imp_0", y, 0);
    for (int k = 0; k < 3; k++) begin
      run_sample(0, 0, 0, 0, 0, y, yr, s);
      chk("zero_imp", y, 0);
    end

    // round half up with OSHIFT=2
    write_coef(0, 1);
    run_sample(6, 0, 0, 0, 0, y, yr, s);
    chk("rnd_pos_raw", y, 6);
    chk("rnd_pos", yr, 2);
    chk("rnd_pos_sat", r_out_sat, 0);
    run_sample(-6, 0, 0, 0, 0, y, yr, s);
    chk("rnd_neg_raw", y, -6);
    chk("rnd_neg", yr, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_serial.md
FIR_MAC_SERIAL -- requirements
Module: fir_mac_serial

Interface
REQ-001 SHALL have parameter NTAPS, default 63, meaning the filter tap count (2..256).
REQ-002 SHALL have parameter DW, default 16, meaning the signed input sample width.
REQ-003 SHALL have parameter CW, default 16, meaning the signed coefficient width.
REQ-004 SHALL have parameter AW, default 40, meaning the signed accumulator width (>= DW+CW+clog2(NTAPS)).
REQ-005 SHALL have parameter OW, default 32, meaning the signed output width.
REQ-006 SHALL have parameter OSHIFT, default 0, meaning the arithmetic right shift applied to the accumulator before saturation.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 in_valid  input  1  input sample offered.
REQ-010 in_ready  output  1  block can accept a sample.
REQ-011 in_data  input  DW  signed input sample.
REQ-012 coef_we  input  1  coefficient write strobe.
REQ-013 coef_addr  input  clog2(NTAPS)  coefficient index k.
REQ-014 coef_wdata  input  CW  signed coefficient value.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  downstream accepts result.
REQ-017 out_data  output  OW  signed filtered result.
REQ-018 out_sat  output  1  result was saturated; qualified by out_valid.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement y[n] = sum over k=0..NTAPS-1 of c[k]*x[n-k], using one multiplier and one accumulator, time-multiplexed.
REQ-021 SHALL hold the last NTAPS accepted samples in a circular delay line addressed by a write pointer that wraps from NTAPS-1 to 0.
REQ-022 SHALL implement the states IDLE, MAC, FINAL and OUT.
REQ-023 IDLE: in_ready=1; on in_valid&in_ready, write in_data at the write pointer, advance the pointer, clear the accumulator, go to MAC.
REQ-024 MAC: SHALL last exactly NTAPS cycles, adding one full-precision product c[k]*x[n-k] (k=0 first) per cycle, sign-extended to AW; then go to FINAL.
REQ-025 FINAL: if OSHIFT>0, add 2^(OSHIFT-1) then shift arithmetically right by OSHIFT (round half up); clamp to [-2^(OW-1), 2^(OW-1)-1]; set out_sat=1 if clamped; register into out_data; go to OUT.
REQ-026 OUT: out_valid=1 with out_data and out_sat stable until the out_valid&out_ready edge, then go to IDLE.
REQ-027 Latency: the acceptance edge is E0; out_valid SHALL rise after edge E0+NTAPS+1.
REQ-028 in_ready SHALL be 0 in MAC, FINAL and OUT; throughput is one sample per NTAPS+3 cycles with out_ready held high.
REQ-029 A coefficient write SHALL take effect only when coef_we=1 in IDLE with coef_addr<NTAPS; otherwise it is ignored.
REQ-030 A coefficient write and a sample acceptance on the same IDLE edge SHALL both occur; the new coefficient SHALL be used for that sample.
REQ-031 Accumulator overflow SHALL not occur for legal AW; no intermediate truncation.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, out_data=0, out_sat=0, busy=0, write pointer=0, all delay-line samples=0 and all coefficients=0, including mid-MAC or mid-OUT; the in-flight result is discarded.

Verification
REQ-033 NTAPS=4, c={1,2,3,4}; inputs 1,0,0,0,0 -> outputs 1,2,3,4,0; out_sat=0.
REQ-034 NTAPS=4, OW=16, all c=32767; four inputs of 32767 -> fourth output 32767 with out_sat=1; same with -32768 inputs -> -32768, out_sat=1.
REQ-035 OSHIFT=2, NTAPS=4, c={1,0,0,0}; inputs 6, -6 -> outputs 2, -1 (round half up).
REQ-036 out_ready held low for 5 cycles in OUT -> out_valid stays 1, out_data stable, in_ready=0; a sample offered meanwhile is accepted only after the handshake.
REQ-037 coef_we to address 0 during MAC -> ignored, current and next outputs unchanged; coef_addr=NTAPS in IDLE -> ignored.
REQ-038 rst_n pulsed low at MAC cycle 2 -> out_valid never asserts for that sample; next impulse input yields all-zero output until coefficients are reloaded.
